// File: rtl/output_backprop.sv
// Backward pass for the output neuron: captures a forward result and its operands, then
// walks the weights one per cycle applying w_k -= (err * x_k) >>> LR_SHIFT with clamping.
module output_backprop #(
   parameter int unsigned N_IN     = 8,
   parameter int unsigned XW       = 10,
   parameter int unsigned WW       = 8,
   parameter int unsigned FW       = 23,
   parameter int unsigned LR_SHIFT = 10
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               en_i,
   input  logic               start_i,
   input  logic [FW-1:0]      final_i,
   input  logic [3:0]         target_i,
   input  logic [N_IN*XW-1:0] x_i,
   input  logic [N_IN*WW-1:0] w_i,
   output logic [N_IN*WW-1:0] w_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_zero_o,
   output logic               sat_o
);

   localparam int unsigned IdxW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int unsigned EW   = FW + 1;
   localparam int unsigned GW   = FW + XW + 2;
   localparam int unsigned NW   = GW + 1;

   localparam logic [IdxW-1:0] IdxLast = IdxW'(N_IN - 1);
   localparam logic [WW-1:0]   WMax    = {WW{1'b1}};

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StErr  = 2'd1;
   localparam logic [1:0] StUpd  = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic [FW-1:0]        final_q, final_d;
   logic [3:0]           target_q, target_d;
   logic [N_IN*XW-1:0]   x_q, x_d;
   logic [N_IN*WW-1:0]   wcap_q, wcap_d;
   logic [N_IN*WW-1:0]   w_q, w_d;
   logic signed [EW-1:0] err_q, err_d;
   logic                 done_q, done_d;
   logic                 err_zero_q, err_zero_d;
   logic                 sat_q, sat_d;

   logic [EW-1:0]        diff;
   logic [XW-1:0]        x_sel;
   logic [WW-1:0]        w_sel;
   logic signed [GW-1:0] err_ext, x_ext, grad, delta;
   logic signed [NW-1:0] wn;

   // Operands are widened to the full gradient width so the product never truncates.
   always_comb begin
      diff    = {1'b0, final_q} - {{(EW-4){1'b0}}, target_q};
      x_sel   = x_q[idx_q*XW +: XW];
      w_sel   = wcap_q[idx_q*WW +: WW];
      err_ext = {{(GW-EW){err_q[EW-1]}}, err_q};
      x_ext   = {{(GW-XW){1'b0}}, x_sel};
      grad    = err_ext * x_ext;
      delta   = grad >>> LR_SHIFT;
      wn      = {{(NW-WW){1'b0}}, w_sel} - {delta[GW-1], delta};
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      final_d    = final_q;
      target_d   = target_q;
      x_d        = x_q;
      wcap_d     = wcap_q;
      w_d        = w_q;
      err_d      = err_q;
      err_zero_d = err_zero_q;
      sat_d      = sat_q;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               final_d    = final_i;
               target_d   = target_i;
               x_d        = x_i;
               wcap_d     = w_i;
               w_d        = w_i;
               err_zero_d = 1'b0;
               sat_d      = 1'b0;
               idx_d      = '0;
               state_d    = StErr;
            end
         end
         StErr: begin
            err_d = $signed(diff);
            if (diff == '0) begin
               err_zero_d = 1'b1;
               state_d    = StDone;
            end else begin
               state_d = StUpd;
            end
         end
         StUpd: begin
            if (wn[NW-1]) begin
               w_d[idx_q*WW +: WW] = '0;
               sat_d               = 1'b1;
            end else if (|wn[NW-2:WW]) begin
               w_d[idx_q*WW +: WW] = WMax;
               sat_d               = 1'b1;
            end else begin
               w_d[idx_q*WW +: WW] = wn[WW-1:0];
            end
            if (idx_q == IdxLast) begin
               state_d = StDone;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // DONE lasts exactly one cycle, so the pulse is simply "next state is DONE".
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         final_q    <= '0;
         target_q   <= '0;
         x_q        <= '0;
         wcap_q     <= '0;
         w_q        <= '0;
         err_q      <= '0;
         done_q     <= 1'b0;
         err_zero_q <= 1'b0;
         sat_q      <= 1'b0;
      end else if (en_i) begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         final_q    <= final_d;
         target_q   <= target_d;
         x_q        <= x_d;
         wcap_q     <= wcap_d;
         w_q        <= w_d;
         err_q      <= err_d;
         done_q     <= done_d;
         err_zero_q <= err_zero_d;
         sat_q      <= sat_d;
      end
   end

   assign w_o        = w_q;
   assign busy_o     = (state_q != StIdle);
   assign done_o     = done_q;
   assign err_zero_o = err_zero_q;
   assign sat_o      = sat_q;

endmodule

// File: tb/tb_output_backprop.sv
// Self-checking bench for output_backprop: directed table, random runs against an arithmetic
// model, and hand-written enable-freeze and mid-run reset sequences.
module tb_output_backprop;

   localparam int N  = 8;
   localparam int XW = 10;
   localparam int WW = 8;
   localparam int FW = 23;

   logic              clk = 1'b0;
   logic              rst_i, en_i, start_i;
   logic [FW-1:0]     final_i;
   logic [3:0]        target_i;
   logic [N*XW-1:0]   x_i;
   logic [N*WW-1:0]   w_i, w_o;
   logic              busy_o, done_o, err_zero_o, sat_o;

   int checks   = 0;
   int failures = 0;

   output_backprop dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .en_i       (en_i),
      .start_i    (start_i),
      .final_i    (final_i),
      .target_i   (target_i),
      .x_i        (x_i),
      .w_i        (w_i),
      .w_o        (w_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_zero_o (err_zero_o),
      .sat_o      (sat_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string         name;
      logic [FW-1:0] fin;
      logic [3:0]    tgt;
      logic [79:0]   x;
      logic [63:0]   w;
      logic [63:0]   ew;
      logic          esat;
      logic          ezero;
      int            elat;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: signed error, exact product, floor division by 2^10, then clamp to 0..255.
   function automatic void model(input logic [FW-1:0] fin, input logic [3:0] tgt,
                                 input logic [79:0] x, input logic [63:0] w,
                                 output logic [63:0] ew, output logic es, output logic ez);
      longint err, g, d, wn;
      err = longint'(fin) - longint'(tgt);
      ez  = (err == 0);
      es  = 1'b0;
      ew  = w;
      if (!ez) begin
         for (int k = 0; k < N; k++) begin
            g = err * longint'(x[k*XW +: XW]);
            d = g / 1024;
            if (g < 0 && (g % 1024) != 0) d = d - 1;
            wn = longint'(w[k*WW +: WW]) - d;
            if (wn < 0) begin
               wn = 0;
               es = 1'b1;
            end else if (wn > 255) begin
               wn = 255;
               es = 1'b1;
            end
            ew[k*WW +: WW] = wn[7:0];
         end
      end
   endfunction

   task automatic wait_done(inout int lat);
      while (!done_o && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic launch(input logic [FW-1:0] fin, input logic [3:0] tgt,
                         input logic [79:0] x, input logic [63:0] w);
      @(negedge clk);
      final_i  = fin;
      target_i = tgt;
      x_i      = x;
      w_i      = w;
      start_i  = 1'b1;
      @(posedge clk);
      #1;
      start_i  = 1'b0;
      final_i  = FW'($urandom);
      target_i = 4'($urandom);
      x_i      = 80'({$urandom, $urandom, $urandom});
      w_i      = {$urandom, $urandom};
   endtask

   task automatic check_run(input string name, input int lat, input int elat,
                            input logic [63:0] ew, input logic es, input logic ez);
      chk({name, ".done_seen"}, 64'(done_o), 64'd1);
      chk({name, ".latency"}, 64'(lat), 64'(elat));
      chk({name, ".w_o"}, w_o, ew);
      chk({name, ".sat"}, 64'(sat_o), 64'(es));
      chk({name, ".err_zero"}, 64'(err_zero_o), 64'(ez));
      @(posedge clk);
      #1;
      chk({name, ".done_pulse"}, 64'(done_o), 64'd0);
      chk({name, ".idle"}, 64'(busy_o), 64'd0);
   endtask

   vec_t          tbl[4];
   logic [79:0]   x1;
   logic [63:0]   w1, ew1;

   initial begin
      int          lat;
      int          busy_cnt;
      logic [63:0] ew;
      logic        es, ez;
      logic [FW-1:0] fin;
      logic [3:0]  tgt;
      logic [79:0] xr;
      logic [63:0] wr;

      x1  = {70'd0, 10'd512};
      w1  = {{7{8'd50}}, 8'd100};
      ew1 = {{7{8'd50}}, 8'd52};
      tbl[0] = '{"T1", 23'd100, 4'd4, x1, w1, ew1, 1'b0, 1'b0, 10};
      tbl[1] = '{"T2", 23'd4, 4'd4, 80'h3ff_1234_5678_9abc_def0, 64'h0102_0304_0506_0708,
                 64'h0102_0304_0506_0708, 1'b0, 1'b1, 2};
      tbl[2] = '{"T3", 23'd100, 4'd4, x1, {{7{8'd50}}, 8'd10}, {{7{8'd50}}, 8'd0},
                 1'b1, 1'b0, 10};
      tbl[3] = '{"T4", 23'd0, 4'd15, {70'd0, 10'd1023}, {{7{8'd50}}, 8'd250},
                 {{7{8'd50}}, 8'd255}, 1'b1, 1'b0, 10};

      rst_i    = 1'b0;
      en_i     = 1'b0;
      start_i  = 1'b0;
      final_i  = '0;
      target_i = '0;
      x_i      = '0;
      w_i      = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.w_o", w_o, 64'd0);
      chk("reset.busy", 64'(busy_o), 64'd0);
      chk("reset.done", 64'(done_o), 64'd0);
      chk("reset.flags", {62'd0, err_zero_o, sat_o}, 64'd0);
      rst_i = 1'b1;
      en_i  = 1'b1;

      for (int i = 0; i < 4; i++) begin
         launch(tbl[i].fin, tbl[i].tgt, tbl[i].x, tbl[i].w);
         chk({tbl[i].name, ".busy"}, 64'(busy_o), 64'd1);
         lat = 1;
         wait_done(lat);
         check_run(tbl[i].name, lat, tbl[i].elat, tbl[i].ew, tbl[i].esat, tbl[i].ezero);
      end

      for (int i = 0; i < 24; i++) begin
         tgt = 4'($urandom);
         if (i % 4 == 0)      fin = FW'(tgt);
         else if (i % 2 == 1) fin = FW'($urandom_range(0, 400));
         else                 fin = FW'($urandom);
         xr = 80'({$urandom, $urandom, $urandom});
         wr = {$urandom, $urandom};
         model(fin, tgt, xr, wr, ew, es, ez);
         launch(fin, tgt, xr, wr);
         lat = 1;
         wait_done(lat);
         check_run($sformatf("rand%0d", i), lat, ez ? 2 : 10, ew, es, ez);
      end

      // T5: enable dropped for 3 cycles at idx 3, start pulsed while busy.
      launch(23'd100, 4'd4, x1, w1);
      lat = 1;
      while (lat < 5) begin
         start_i = (lat == 3);
         @(posedge clk);
         #1;
         lat++;
      end
      en_i    = 1'b0;
      start_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      lat += 3;
      chk("T5.frozen_w", w_o, ew1);
      chk("T5.frozen_busy", 64'(busy_o), 64'd1);
      chk("T5.frozen_done", 64'(done_o), 64'd0);
      en_i    = 1'b1;
      start_i = 1'b0;
      wait_done(lat);
      check_run("T5", lat, 13, ew1, 1'b0, 1'b0);
      busy_cnt = 0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (busy_o) busy_cnt++;
      end
      chk("T5.no_queued_start", 64'(busy_cnt), 64'd0);

      // T6: reset asserted at idx 5 aborts the run.
      launch(23'd100, 4'd4, x1, {{7{8'd50}}, 8'd10});
      lat = 1;
      while (lat < 7) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("T6.sat_before_reset", 64'(sat_o), 64'd1);
      rst_i = 1'b0;
      @(posedge clk);
      #1;
      rst_i = 1'b1;
      chk("T6.w_o", w_o, 64'd0);
      chk("T6.busy", 64'(busy_o), 64'd0);
      chk("T6.flags", {62'd0, err_zero_o, sat_o}, 64'd0);
      busy_cnt = 0;
      repeat (12) begin
         if (done_o || busy_o) busy_cnt++;
         @(posedge clk);
         #1;
      end
      chk("T6.no_done", 64'(busy_cnt), 64'd0);
      launch(23'd100, 4'd4, x1, w1);
      lat = 1;
      wait_done(lat);
      check_run("T6.rerun", lat, 10, ew1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
